// File: rtl/pixel_word_packer.sv
// Packs an 8-bit pixel stream into little-endian 32-bit words and buffers them
// in a small FIFO whose head is read by the CPU; each ack_toggle edge pops one word.
module pixel_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         pix_data_i,
  input  logic               pix_valid_i,
  input  logic               pix_sof_i,
  output logic               pix_ready_o,
  input  logic               flush_i,
  input  logic               ack_toggle_i,
  output logic [31:0]        word_out_o,
  output logic               word_valid_o,
  output logic               word_sof_o,
  output logic [LEVEL_W-1:0] fifo_level_o,
  output logic               sof_drop_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [23:0]        part_q, part_d;
  logic               part_sof_q, part_sof_d;
  logic               sof_drop_q, sof_drop_d;
  logic               ack_q;

  logic   empty, full, accept, restart, push, pop, ack_evt;
  entry_t head;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LEVEL_W'(FIFO_DEPTH));
  // Readiness ignores a same-cycle pop so ack_toggle never reaches pix_ready.
  assign pix_ready_o = reset_n && !flush_i && ((cnt_q != 2'd3) || !full);
  assign accept  = pix_valid_i && pix_ready_o;
  assign restart = accept && pix_sof_i && (cnt_q != 2'd0);
  assign push    = accept && !restart && (cnt_q == 2'd3);
  assign ack_evt = ack_toggle_i ^ ack_q;
  assign pop     = ack_evt && !empty && !flush_i;

  assign head         = mem_q[rd_ptr_q];
  assign word_out_o   = empty ? 32'h0 : head.data;
  assign word_sof_o   = !empty && head.sof;
  assign word_valid_o = !empty;
  assign fifo_level_o = level_q;
  assign sof_drop_o   = sof_drop_q;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    part_sof_d = part_sof_q;
    sof_drop_d = sof_drop_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      cnt_d      = 2'd0;
      part_sof_d = 1'b0;
      sof_drop_d = 1'b0;
    end else begin
      if (restart) begin
        // Start-of-frame mid-word: drop the partial word and restart at pixel 0.
        part_d[7:0] = pix_data_i;
        part_sof_d  = 1'b1;
        sof_drop_d  = 1'b1;
        cnt_d       = 2'd1;
      end else if (accept) begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin
            part_d[7:0] = pix_data_i;
            part_sof_d  = pix_sof_i;
          end
          2'd1:    part_d[15:8]  = pix_data_i;
          2'd2:    part_d[23:16] = pix_data_i;
          default: ;
        endcase
      end
      if (push) begin
        mem_d[wr_ptr_q] = '{sof: part_sof_q, data: {pix_data_i, part_q}};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= 2'd0;
      part_q     <= '0;
      part_sof_q <= 1'b0;
      sof_drop_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      part_sof_q <= part_sof_d;
      sof_drop_q <= sof_drop_d;
      ack_q      <= ack_toggle_i;
    end
  end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Upstream feeder for the 32-bit pixel_data PIO input port read by the Nios II.
- Collects an 8-bit pixel stream (valid/ready) into 32-bit words of 4 pixels and buffers them in a small FIFO.
- Presents the FIFO head on word_out, which wires to the PIO in_port.
- The CPU consumes one word per toggle of a CPU-driven PIO output bit (ack_toggle), so a level-only PIO still gives a lossless handshake.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of 2, minimum 2.
- LEVEL_W, 3, width of fifo_level; must hold values 0..FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- pix_data  in  8  pixel value.
- pix_valid  in  1  pix_data valid this cycle.
- pix_sof  in  1  qualifies the pixel as first of frame; meaningful only with pix_valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- flush  in  1  synchronous clear of FIFO and partial word.
- ack_toggle  in  1  CPU PIO bit; each change of level pops one word.
- word_out  out  32  FIFO head, to PIO in_port; 0 when empty.
- word_valid  out  1  FIFO non-empty.
- word_sof  out  1  head word contains first pixel of a frame.
- fifo_level  out  LEVEL_W  number of words held.
- sof_drop  out  1  sticky; a partial word was discarded by pix_sof; cleared by flush.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. While reset_n=0, every register and output is 0, including ack_q, which therefore samples ack_toggle on the first clock after release.
- Accept: a pixel is accepted on a rising edge with pix_valid=1 and pix_ready=1.
- Packing: little-endian. Pixel k of a word (k = 0..3, counter cnt) goes to bits [8k+7:8k]. A 2-bit cnt increments per accepted pixel and wraps 3 -> 0.
- Push: accepting with cnt=3 writes the full word and its sof flag into the FIFO on that edge.
  - word_valid, word_out and fifo_level reflect the new entry from the next cycle.
  - Latency: 1 cycle when the FIFO was empty.
- pix_ready: 1 when cnt != 3 or fifo_level < FIFO_DEPTH; 0 while flush=1.
  - Does not depend on a same-cycle pop, so there is no combinational path from ack_toggle.
  - FIFO overflow is therefore impossible.
- pix_sof accepted with cnt != 0:
  - Partial word is discarded and sof_drop is set.
  - The pixel becomes pixel 0 of a new word, with the word sof flag set; cnt = 1.
- pix_sof accepted with cnt = 0: normal pixel 0 with the sof flag set.
- Pop:
  - ack_q is registered from ack_toggle every cycle.
  - ack_evt = ack_toggle XOR ack_q.
  - ack_evt with word_valid=1 pops the head on that edge.
  - ack_evt with FIFO empty is ignored and does not pop a later word.
- Simultaneous push and pop: both happen and fifo_level is unchanged. With a single entry, word_out shows the pushed word next cycle.
- Pointers: rd/wr pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_level.
- flush has priority over push, pop and sof handling. Effects on the edge:
  - fifo_level=0, cnt=0, sof_drop=0.
  - Any ack_evt in that cycle is consumed (ack_q still updates).
- word_out: combinational from the head entry register, forced to 0 when empty. word_sof is 0 when empty.
- Reset mid-word or mid-frame: all content is lost and no partial word is ever emitted.

Test Plan:
- Reset, then pixels 0x11,0x22,0x33,0x44 with pix_sof on the first -> next cycle word_out=0x44332211, word_valid=1, word_sof=1, fifo_level=1.
- Push 5 words without ack (FIFO_DEPTH=4) -> fifo_level=4; pix_ready drops only when cnt=3. Then toggle ack_toggle once -> word 0 popped, pix_ready=1 next cycle, and 5th word enters after its 4th pixel.
- Pixels 0xAA,0xBB, then pix_sof with 0x01,0x02,0x03,0x04 -> sof_drop=1; the only word is 0x04030201 with word_sof=1.
- Toggle ack_toggle with FIFO empty, then push one word -> word stays valid (ack not remembered); fifo_level=1.
- fifo_level=1 and cnt=3; 4th pixel accepted in the same cycle as ack_evt -> fifo_level stays 1 and word_out changes to the new word.
- Assert flush with 3 words plus 2 pending pixels and an ack toggle in the same cycle -> fifo_level=0, word_out=0, sof_drop=0; next 4 pixels form a fresh word. Also assert reset_n low mid-word -> all outputs 0 asynchronously.
